// File: rtl/rs_station.sv
// Reservation station: holds issued instructions until both operands are
// valid, snoops the CDB for pending operands, dispatches the lowest-index
// ready entry to the functional unit and requests a rename of the
// destination register for every accepted issue.
module rs_station #(
  parameter int               NUM_ENTRIES = 4,
  parameter int               DATA_W      = 32,
  parameter int               TAG_W       = 5,
  parameter int               OP_W        = 5,
  parameter int               RS_TAG_BASE = 0,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_val_1,
  input  logic [DATA_W-1:0] issue_val_2,
  input  logic [TAG_W-1:0]  issue_tag_1,
  input  logic [TAG_W-1:0]  issue_tag_2,
  input  logic [4:0]        issue_dest_reg,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_val_1,
  output logic [DATA_W-1:0] disp_val_2,
  output logic [TAG_W-1:0]  disp_tag,
  output logic              bank_enable,
  output logic [4:0]        bank_reg,
  output logic [TAG_W-1:0]  bank_tag
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  // Entry tags must never alias the "nothing pending" marker.
  if ((NUM_ENTRIES < 2) || (NUM_ENTRIES > 16)) begin : g_bad_size
    $error("rs_station: NUM_ENTRIES must be in 2..16");
  end
  if (RS_TAG_BASE + NUM_ENTRIES - 1 >= int'(INVALID_TAG)) begin : g_bad_tags
    $error("rs_station: entry tags collide with INVALID_TAG");
  end

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]        op_q   [NUM_ENTRIES];
  logic [OP_W-1:0]        op_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag1_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag1_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag2_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag2_d [NUM_ENTRIES];

  logic             bank_enable_q;
  logic [4:0]       bank_reg_q;
  logic [TAG_W-1:0] bank_tag_q;

  logic [NUM_ENTRIES-1:0] entry_rdy;
  logic [IDX_W-1:0]       free_idx, sel_idx;
  logic                   any_free, any_ready;
  logic                   accept, fire, cdb_hit;

  // An entry is ready once it holds both operand values.
  always_comb begin
    entry_rdy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_rdy[i] = busy_q[i] && (tag1_q[i] == INVALID_TAG) && (tag2_q[i] == INVALID_TAG);
    end
  end

  // Priority pick of the lowest free slot and the lowest ready slot.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    any_free  = 1'b0;
    any_ready = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
      if (entry_rdy[i]) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign issue_ready = any_free;
  assign accept      = issue_valid && any_free;
  assign disp_valid  = any_ready;
  assign fire        = any_ready && disp_ready;
  assign cdb_hit     = cdb_valid && (cdb_tag != INVALID_TAG);

  assign disp_op    = op_q[sel_idx];
  assign disp_val_1 = val1_q[sel_idx];
  assign disp_val_2 = val2_q[sel_idx];
  assign disp_tag   = TAG_W'(RS_TAG_BASE) + TAG_W'(sel_idx);

  assign bank_enable = bank_enable_q;
  assign bank_reg    = bank_reg_q;
  assign bank_tag    = bank_tag_q;

  // Entry next state: CDB wake-up, dispatch release and issue write.
  // The issue slot is free, so it never overlaps the snoop or release.
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    val1_d = val1_q;
    val2_d = val2_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[i] && cdb_hit) begin
        if (tag1_q[i] == cdb_tag) begin
          val1_d[i] = cdb_val;
          tag1_d[i] = INVALID_TAG;
        end
        if (tag2_q[i] == cdb_tag) begin
          val2_d[i] = cdb_val;
          tag2_d[i] = INVALID_TAG;
        end
      end
      if (fire && (sel_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (accept && (free_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        if (cdb_hit && (issue_tag_1 == cdb_tag)) begin
          val1_d[i] = cdb_val;
          tag1_d[i] = INVALID_TAG;
        end else begin
          val1_d[i] = issue_val_1;
          tag1_d[i] = issue_tag_1;
        end
        if (cdb_hit && (issue_tag_2 == cdb_tag)) begin
          val2_d[i] = cdb_val;
          tag2_d[i] = INVALID_TAG;
        end else begin
          val2_d[i] = issue_val_2;
          tag2_d[i] = issue_tag_2;
        end
      end
    end
  end

  // Entry storage; reset only needs to drop the busy bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  // Rename request: one-cycle pulse after each accept, reg/tag hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_enable_q <= 1'b0;
      bank_reg_q    <= '0;
      bank_tag_q    <= '0;
    end else begin
      bank_enable_q <= accept;
      if (accept) begin
        bank_reg_q <= issue_dest_reg;
        bank_tag_q <= TAG_W'(RS_TAG_BASE) + TAG_W'(free_idx);
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios followed by random traffic, all
// checked cycle by cycle against a slot-level model of the station.
module tb_rs_station;
  localparam int N = 4;
  localparam logic [4:0] INV = 5'h1f;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_op;
  logic [31:0] issue_val_1, issue_val_2;
  logic [4:0]  issue_tag_1, issue_tag_2;
  logic [4:0]  issue_dest_reg;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_op;
  logic [31:0] disp_val_1, disp_val_2;
  logic [4:0]  disp_tag;
  logic        bank_enable;
  logic [4:0]  bank_reg, bank_tag;

  always #5 clk = ~clk;

  rs_station #(.NUM_ENTRIES(N), .DATA_W(32), .TAG_W(5), .OP_W(5),
               .RS_TAG_BASE(0), .INVALID_TAG(INV)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_val_1(issue_val_1), .issue_val_2(issue_val_2),
    .issue_tag_1(issue_tag_1), .issue_tag_2(issue_tag_2),
    .issue_dest_reg(issue_dest_reg),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_val_1(disp_val_1), .disp_val_2(disp_val_2), .disp_tag(disp_tag),
    .bank_enable(bank_enable), .bank_reg(bank_reg), .bank_tag(bank_tag)
  );

  typedef struct {
    logic        ir, dv, be;
    logic [4:0]  breg, btag;
    logic [4:0]  op, tag;
    logic [31:0] v1, v2;
  } exp_t;

  exp_t exp_q[$];

  // reference slots
  bit          m_busy [N];
  logic [4:0]  m_op   [N];
  logic [31:0] m_v1   [N];
  logic [31:0] m_v2   [N];
  logic [4:0]  m_t1   [N];
  logic [4:0]  m_t2   [N];
  logic        m_be;
  logic [4:0]  m_breg, m_btag;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 0;
    m_be = 0; m_breg = 0; m_btag = 0;
  endtask

  // Predict this cycle's outputs from the current slots, then apply the cycle.
  task automatic model_cycle();
    exp_t e;
    int sel = -1, fr = -1, cnt = 0;
    bit acc;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) cnt++;
      if (sel < 0 && m_busy[i] && m_t1[i] == INV && m_t2[i] == INV) sel = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    e.ir = (cnt < N); e.dv = (sel >= 0);
    e.be = m_be; e.breg = m_breg; e.btag = m_btag;
    e.op = 0; e.v1 = 0; e.v2 = 0; e.tag = 0;
    if (sel >= 0) begin
      e.op = m_op[sel]; e.v1 = m_v1[sel]; e.v2 = m_v2[sel]; e.tag = 5'(sel);
    end
    exp_q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      acc = issue_valid && (fr >= 0);
      if (cdb_valid && cdb_tag != INV) begin
        for (int i = 0; i < N; i++) begin
          if (m_busy[i] && m_t1[i] == cdb_tag) begin m_v1[i] = cdb_val; m_t1[i] = INV; end
          if (m_busy[i] && m_t2[i] == cdb_tag) begin m_v2[i] = cdb_val; m_t2[i] = INV; end
        end
      end
      if (sel >= 0 && disp_ready) m_busy[sel] = 0;
      m_be = acc;
      if (acc) begin
        m_busy[fr] = 1;
        m_op[fr]   = issue_op;
        m_v1[fr] = issue_val_1; m_t1[fr] = issue_tag_1;
        m_v2[fr] = issue_val_2; m_t2[fr] = issue_tag_2;
        if (cdb_valid && cdb_tag != INV && issue_tag_1 == cdb_tag) begin m_v1[fr] = cdb_val; m_t1[fr] = INV; end
        if (cdb_valid && cdb_tag != INV && issue_tag_2 == cdb_tag) begin m_v2[fr] = cdb_val; m_t2[fr] = INV; end
        m_breg = issue_dest_reg;
        m_btag = 5'(fr);
      end
    end
  endtask

  task automatic set_idle();
    rst = 0; issue_valid = 0; issue_op = 0; issue_val_1 = 0; issue_val_2 = 0;
    issue_tag_1 = INV; issue_tag_2 = INV; issue_dest_reg = 0;
    cdb_valid = 0; cdb_tag = INV; cdb_val = 0; disp_ready = 0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] t1, input logic [4:0] t2, input logic [4:0] dest);
    issue_valid = 1; issue_op = op; issue_val_1 = v1; issue_val_2 = v2;
    issue_tag_1 = t1; issue_tag_2 = t2; issue_dest_reg = dest;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_val = val;
  endtask

  task automatic step(input bit dr);
    disp_ready = dr;
    model_cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  function automatic logic [4:0] pick_tag();
    case ($urandom_range(0, 7))
      4:       return 5'd7;
      5:       return 5'd9;
      6:       return 5'd12;
      7:       return 5'($urandom_range(0, 3));
      default: return INV;
    endcase
  endfunction

  // Monitor: compare what the DUT presents each cycle with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_ready", issue_ready, e.ir);
        check("disp_valid", disp_valid, e.dv);
        check("bank_enable", bank_enable, e.be);
        check("bank_reg_tag", {bank_reg, bank_tag}, {e.breg, e.btag});
        if (e.dv)
          check("disp_payload", {disp_op, disp_val_1, disp_val_2, disp_tag},
                {e.op, e.v1, e.v2, e.tag});
      end
    end
  end

  initial begin
    set_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // ready at issue, dispatched the next cycle
    issue(5'd3, 32'd10, 32'd20, INV, INV, 5'd5); step(1);
    step(1);
    step(1);

    // operand 1 woken by CDB tag 7
    issue(5'd1, 32'd0, 32'd33, 5'd7, INV, 5'd6); step(1);
    step(1);
    cdb(5'd7, 32'hAB); step(1);
    step(1);
    step(1);

    // fill with entries waiting on tag 9, fifth issue ignored, then drain in order
    for (int i = 0; i < N; i++) begin
      issue(5'(i + 8), 32'(i), 32'(i + 100), 5'd9, 5'd9, 5'(i + 1)); step(0);
    end
    issue(5'd2, 32'd1, 32'd2, INV, INV, 5'd20); step(0);
    cdb(5'd9, 32'h1234_5678); step(1);
    repeat (N + 1) step(1);

    // issue-time bypass of operand 2
    issue(5'd4, 32'd77, 32'd0, INV, 5'd12, 5'd9); cdb(5'd12, 32'd5); step(1);
    step(1);
    step(1);

    // full station: dispatch frees a slot that is only usable the next cycle
    for (int i = 0; i < N; i++) begin
      issue(5'(i), 32'(i * 3), 32'(i * 5), INV, INV, 5'(i + 10)); step(0);
    end
    issue(5'd15, 32'd111, 32'd222, INV, INV, 5'd30); step(1);
    issue(5'd15, 32'd111, 32'd222, INV, INV, 5'd30); step(0);
    step(0);

    // reset with three busy entries
    step(1);
    rst = 1; step(0);
    cdb(5'd9, 32'd1); step(1);
    cdb(5'd0, 32'd2); step(1);
    step(1);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; step(0);
      end else begin
        if ($urandom_range(0, 99) < 60)
          issue(5'($urandom), $urandom, $urandom, pick_tag(), pick_tag(), 5'($urandom));
        if ($urandom_range(0, 99) < 50)
          cdb(pick_tag(), $urandom);
        step($urandom_range(0, 99) < 70);
      end
    end
    repeat (3) step(1);

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
